// File: rtl/stack_ctrl.sv
// PC return-address stack shared by the control unit (CALL/RET) and the interrupt unit (IRQ/RETI).
// Each push or pop is a two-cycle transaction: grant in IDLE, acknowledge in DONE.
module stack_ctrl #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cu_req,
  input  logic             cu_op,
  input  logic [WIDTH-1:0] cu_pc_in,
  output logic             cu_ack,
  input  logic             irq_req,
  input  logic             irq_op,
  input  logic [WIDTH-1:0] irq_pc_in,
  output logic             irq_ack,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_out_valid,
  output logic [AW:0]      sp,
  output logic             full,
  output logic             empty,
  output logic             ovf_err,
  output logic             unf_err,
  input  logic             err_clr
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration and stack update happen on the leaving edge
  // DONE  | granted requester's ack (and pc_out_valid for a good pop) is presented
  typedef enum logic {IDLE = 1'b0, DONE = 1'b1} state_t;

  localparam logic [AW:0] SP_MAX = (AW+1)'(DEPTH);

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             grant;
  logic             g_irq;
  logic             g_op;
  logic [WIDTH-1:0] g_pc;
  logic             do_push;
  logic             do_pop;
  logic             bad_push;
  logic             bad_pop;
  logic [AW:0]      sp_dec;

  assign full  = (sp == SP_MAX);
  assign empty = (sp == '0);

  // Interrupt unit has fixed priority; a losing cu_req stays pending.
  assign grant    = (state == IDLE) && (cu_req || irq_req);
  assign g_irq    = irq_req;
  assign g_op     = irq_req ? irq_op : cu_op;
  assign g_pc     = irq_req ? irq_pc_in : cu_pc_in;
  assign do_push  = grant && !g_op && !full;
  assign bad_push = grant && !g_op &&  full;
  assign do_pop   = grant &&  g_op && !empty;
  assign bad_pop  = grant &&  g_op &&  empty;
  assign sp_dec   = sp - 1'b1;

  always_ff @(posedge clk) begin
    if (do_push) mem[sp[AW-1:0]] <= g_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      sp           <= '0;
      cu_ack       <= 1'b0;
      irq_ack      <= 1'b0;
      pc_out_valid <= 1'b0;
      pc_out       <= '0;
      ovf_err      <= 1'b0;
      unf_err      <= 1'b0;
    end else begin
      cu_ack       <= 1'b0;
      irq_ack      <= 1'b0;
      pc_out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state   <= DONE;
            irq_ack <= g_irq;
            cu_ack  <= !g_irq;
            if (do_push) sp <= sp + 1'b1;
            if (do_pop) begin
              sp           <= sp_dec;
              pc_out       <= mem[sp_dec[AW-1:0]];
              pc_out_valid <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      // A new error wins over a simultaneous clear.
      ovf_err <= bad_push | (ovf_err & ~err_clr);
      unf_err <= bad_pop  | (unf_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a queue-based stack model predicts each response,
// and a monitor compares whenever the DUT acknowledges.
module tb_stack_ctrl;
  localparam int WIDTH = 18;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cu_req = 1'b0, cu_op = 1'b0;
  logic [WIDTH-1:0] cu_pc_in = '0;
  logic             cu_ack;
  logic             irq_req = 1'b0, irq_op = 1'b0;
  logic [WIDTH-1:0] irq_pc_in = '0;
  logic             irq_ack;
  logic [WIDTH-1:0] pc_out;
  logic             pc_out_valid;
  logic [AW:0]      sp;
  logic             full, empty, ovf_err, unf_err;
  logic             err_clr = 1'b0;

  stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cu_req(cu_req), .cu_op(cu_op), .cu_pc_in(cu_pc_in), .cu_ack(cu_ack),
    .irq_req(irq_req), .irq_op(irq_op), .irq_pc_in(irq_pc_in), .irq_ack(irq_ack),
    .pc_out(pc_out), .pc_out_valid(pc_out_valid), .sp(sp),
    .full(full), .empty(empty), .ovf_err(ovf_err), .unf_err(unf_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             is_irq;
    bit             valid;
    bit [WIDTH-1:0] pc;
    int             sp;
    bit             full, empty, ovf, unf;
  } exp_t;

  exp_t           expq[$];
  bit [WIDTH-1:0] stk[$];
  bit [WIDTH-1:0] m_pc;
  bit             m_ovf, m_unf;
  int             errors = 0;
  int             checks = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_pc  = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Reference behaviour: LIFO of at most DEPTH entries, errors set-dominant over clear.
  task automatic model_apply(input bit is_irq, input bit op, input bit [WIDTH-1:0] pc,
                             input bit clr, output exp_t e);
    bit so = 1'b0, su = 1'b0;
    e.valid = 1'b0;
    if (!op) begin
      if (stk.size() < DEPTH) stk.push_back(pc);
      else so = 1'b1;
    end else begin
      if (stk.size() > 0) begin
        m_pc = stk.pop_back();
        e.valid = 1'b1;
      end else su = 1'b1;
    end
    m_ovf    = so ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf    = su ? 1'b1 : (clr ? 1'b0 : m_unf);
    e.is_irq = is_irq;
    e.pc     = m_pc;
    e.sp     = stk.size();
    e.full   = (stk.size() == DEPTH);
    e.empty  = (stk.size() == 0);
    e.ovf    = m_ovf;
    e.unf    = m_unf;
  endtask

  // Monitor: compare every acknowledged transaction against the next prediction.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_out_valid && !(cu_ack || irq_ack)) chk("valid_without_ack", 1, 0);
      if (cu_ack && irq_ack) chk("double_ack", 1, 0);
      else if (cu_ack || irq_ack) begin
        if (expq.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          exp_t e;
          e = expq.pop_front();
          chk("ack_owner_irq", irq_ack, e.is_irq);
          chk("pc_out_valid", pc_out_valid, e.valid);
          chk("pc_out", pc_out, e.pc);
          chk("sp", sp, e.sp);
          chk("full", full, e.full);
          chk("empty", empty, e.empty);
          chk("ovf_err", ovf_err, e.ovf);
          chk("unf_err", unf_err, e.unf);
        end
      end
    end
  end

  task automatic do_txn(input bit is_irq, input bit op, input bit [WIDTH-1:0] pc, input bit clr);
    exp_t e;
    int   lat;
    model_apply(is_irq, op, pc, clr, e);
    expq.push_back(e);
    @(negedge clk);
    if (is_irq) begin irq_req = 1'b1; irq_op = op; irq_pc_in = pc; end
    else        begin cu_req  = 1'b1; cu_op  = op; cu_pc_in  = pc; end
    err_clr = clr;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(is_irq ? irq_ack : cu_ack) && lat < 8);
    chk("ack_latency", lat, 1);
    cu_req  = 1'b0;
    irq_req = 1'b0;
    err_clr = 1'b0;
  endtask

  // Both requesters rise together; the interrupt unit must be served first.
  task automatic do_pair(input bit irq_o, input bit [WIDTH-1:0] irq_pc,
                         input bit cu_o, input bit [WIDTH-1:0] cu_pc);
    exp_t e;
    int   n = 0;
    bit   got_i = 1'b0, got_c = 1'b0;
    model_apply(1'b1, irq_o, irq_pc, 1'b0, e);
    expq.push_back(e);
    model_apply(1'b0, cu_o, cu_pc, 1'b0, e);
    expq.push_back(e);
    @(negedge clk);
    irq_req = 1'b1; irq_op = irq_o; irq_pc_in = irq_pc;
    cu_req  = 1'b1; cu_op  = cu_o;  cu_pc_in  = cu_pc;
    while (!(got_i && got_c) && n < 12) begin
      @(negedge clk);
      n++;
      if (irq_ack) begin got_i = 1'b1; irq_req = 1'b0; end
      if (cu_ack)  begin got_c = 1'b1; cu_req  = 1'b0; end
    end
    chk("pair_done_cycles", n, 3);
    irq_req = 1'b0;
    cu_req  = 1'b0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    chk("ovf_after_clr", ovf_err, 0);
    chk("unf_after_clr", unf_err, 0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sp"}, sp, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_acks"}, {cu_ack, irq_ack, pc_out_valid}, 0);
    chk({tag, "_pc_out"}, pc_out, 0);
    chk({tag, "_errs"}, {ovf_err, unf_err}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    do_txn(1'b0, 1'b0, 18'h00100, 1'b0);
    do_txn(1'b0, 1'b1, 18'h0, 1'b0);

    do_pair(1'b0, 18'h3FFFF, 1'b0, 18'h00AAA);
    do_txn(1'b0, 1'b1, 18'h0, 1'b0);
    do_txn(1'b1, 1'b1, 18'h0, 1'b0);

    for (int i = 0; i < DEPTH; i++) do_txn(i[0], 1'b0, 18'(i * 37 + 5), 1'b0);
    do_txn(1'b0, 1'b0, 18'h12345, 1'b0);
    clear_errs();
    for (int i = 0; i < DEPTH; i++) do_txn(1'b0, 1'b1, 18'h0, 1'b0);

    do_txn(1'b0, 1'b1, 18'h0, 1'b0);
    do_txn(1'b1, 1'b1, 18'h0, 1'b1);
    clear_errs();

    // Reset lands in the DONE cycle of a push.
    @(negedge clk);
    cu_req = 1'b1; cu_op = 1'b0; cu_pc_in = 18'h0BEEF;
    @(posedge clk);
    #1 rst_n = 1'b0;
    cu_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 18'h2A5A5, 1'b0);
    do_txn(1'b0, 1'b1, 18'h0, 1'b0);

    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 120; i++) begin
        bit op;
        case (ph)
          0:       op = ($urandom_range(0, 3) == 0);
          1:       op = ($urandom_range(0, 3) != 0);
          default: op = $urandom_range(0, 1) == 1;
        endcase
        if ($urandom_range(0, 9) == 0)
          do_pair($urandom_range(0, 1) == 1, 18'($urandom), $urandom_range(0, 1) == 1, 18'($urandom));
        else
          do_txn($urandom_range(0, 1) == 1, op, 18'($urandom), $urandom_range(0, 7) == 0);
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
